mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Request front-end for the dual-port byte RAM in the softcore CPU. Accepts instruction-fetch and load/store requests over valid/ready handshakes and arbitrates between them round-robin. Drives both RAM ports so that a 16-bit access completes in a single RAM cycle. Returns little-endian read data and write acknowledgements one-shot, two cycles after acceptance.

## Interface
- ADDR_W, 8, RAM address width (256 entries)
- DATA_W, 8, RAM word width (byte addressable)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted when valid&ready
- if_addr  in  ADDR_W  fetch byte address (always halfword read)
- if_rsp_valid  out  1  one-cycle fetch response strobe
- if_rsp_data  out  2*DATA_W  instruction, {mem[a+1], mem[a]}
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store accepted when valid&ready
- ls_addr  in  ADDR_W  byte address
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  1  0 = byte, 1 = halfword
- ls_wdata  in  2*DATA_W  store data (byte store uses [7:0])
- ls_rsp_valid  out  1  one-cycle load data / store ack strobe
- ls_rsp_data  out  2*DATA_W  load data; 0 for stores
- ram_en  out  1  RAM enable (clock-gate enable)
- ram_addr_1, ram_addr_2  out  ADDR_W  port addresses
- ram_wdata_1, ram_wdata_2  out  DATA_W  port write data
- ram_rw_1, ram_rw_2  out  1  0 = read, 1 = write
- ram_rdata_1, ram_rdata_2  in  DATA_W  registered RAM read data

## Operation
- FSM: IDLE -> ACCESS -> RESP -> IDLE. No other transitions except reset.
- IDLE: ready asserted to the granted requester only; on handshake, latch the request (source, addr, we, size, wdata) and go to ACCESS.
- Arbitration: a single valid requester wins. When both are valid, the one not granted last wins. last_grant resets to LS, so fetch wins the first tie.
- ACCESS: ram_en=1; port 1 gets addr, port 2 gets (addr+1) mod 2^ADDR_W.
  - Halfword store: port1 writes wdata[7:0], port2 writes wdata[15:8].
  - Byte store: port1 writes wdata[7:0]; port2 reads.
  - Loads and fetches: both ports read.
  - The two port addresses always differ, so there is no same-address write conflict.
- RESP: ram_en=0 so RAM outputs hold. Assert rsp_valid of the latched source for exactly one cycle.
  - Halfword read data = {ram_rdata_2, ram_rdata_1}.
  - Byte read data = {8'h00, ram_rdata_1}.
  - Store response data = 0.
- Responses have no backpressure; the requester must sample in RESP.
- Outside ACCESS: all ram_* outputs are 0. Outside RESP: rsp_valid and rsp_data are 0.

## Timing
- Reset (async assert, synchronous to clk on release): state=IDLE, last_grant=LS, latched request cleared; every output 0 except ready, which follows the IDLE grant rule combinationally.
- Handshake at posedge T -> ACCESS during cycle T+1 -> RESP during T+2 -> ready again in T+3. Throughput is one access per 3 cycles.
- ready is 0 in ACCESS and RESP. Requests held valid there are not accepted and may not change until accepted.
- Address wrap: halfword at 0xFF uses bytes 0xFF (low) and 0x00 (high).
- Reset asserted in ACCESS or RESP: the access is aborted and no response is issued. A store in ACCESS may or may not have landed in RAM.
- Both requesters valid in the same cycle: exactly one is granted; the other sees ready=0.

## Structure
- Shared package mem_pkg: state encoding (IDLE/ACCESS/RESP), size encoding (SZ_BYTE=0, SZ_HALF=1), source encoding (SRC_IF, SRC_LS).
- Sub-module rr_arb2: 2-way round-robin arbiter with last_grant register, grants only when enabled (state==IDLE).
- Estimated 150-250 lines of RTL, excluding the RAM itself.

## Test plan
- Reset check: drive rst_n low mid-ACCESS -> all rsp_valid and ram_* outputs 0 immediately; IDLE after release; no response issued.
- Store then load, byte access:
  - Stimulus: ls store byte 0xA5 to 0x10, then byte load from 0x10.
  - Required response: ls_rsp_data=0x00A5, two cycles after load accept; port2 rw=0 during the byte store.
- Wrap-around halfword:
  - Stimulus: halfword store 0xBEEF to 0xFF, then fetch from 0xFF.
  - Required response: mem[0xFF]=0xEF, mem[0x00]=0xBE, if_rsp_data=0xBEEF.
- Contention:
  - Stimulus: if and ls held valid continuously from reset.
  - Required response: grants alternate IF, LS, IF, LS; each ready pulse is 3 cycles apart.
- Latency and hold:
  - Stimulus: fetch accepted at T while ls_req_valid rises at T+1.
  - Required response: if_rsp_valid only at T+2; ls accepted at T+3; ls_rsp_valid at T+5.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RAM request front-end.
//   state_t : controller FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   size_t  : access size of a load/store request
//   src_t   : which requester owns the in-flight access
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_HALF = 1'b1
  } size_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and load/store.
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : arbitration allowed (controller idle)
//   req_if, req_ls  : request valids
//   gnt_if, gnt_ls  : one-hot grant; a grant is also the handshake, since
//                     it is only given to a requester that is valid
// On a tie the requester not granted last wins; last_grant starts at LS
// so fetch wins the first tie after reset.
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_if,
  input  logic req_ls,
  output logic gnt_if,
  output logic gnt_ls
);

  src_t last_grant;

  always_comb begin
    // NOTE: defaults first so every path assigns the outputs; a missing
    // assignment on any branch would otherwise infer a latch.
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (en) begin
      if (req_if && req_ls) begin
        gnt_if = (last_grant == SRC_LS);
        gnt_ls = (last_grant == SRC_IF);
      end else begin
        gnt_if = req_if;
        gnt_ls = req_ls;
      end
    end
  end

  // NOTE: non-blocking assignments in clocked logic so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_LS;
    end else if (gnt_if) begin
      last_grant <= SRC_IF;
    end else if (gnt_ls) begin
      last_grant <= SRC_LS;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Request front-end for the dual-port byte RAM.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr   : fetch request (always halfword read)
//   if_rsp_valid, if_rsp_data     : one-cycle fetch response
//   ls_req_valid/ready, ls_addr,
//   ls_we, ls_size, ls_wdata      : load/store request
//   ls_rsp_valid, ls_rsp_data     : one-cycle load data / store ack
//   ram_en, ram_addr_*, ram_wdata_*,
//   ram_rw_*, ram_rdata_*         : both RAM ports; rdata is registered
// Port 1 always carries the low byte at addr, port 2 the high byte at
// addr+1 (wrapping), so a halfword completes in one RAM cycle. Response
// appears two cycles after the accepting edge.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [2*DATA_W-1:0] if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_we,
  input  logic                ls_size,
  input  logic [2*DATA_W-1:0] ls_wdata,
  output logic                ls_rsp_valid,
  output logic [2*DATA_W-1:0] ls_rsp_data,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr_1,
  output logic [ADDR_W-1:0]   ram_addr_2,
  output logic [DATA_W-1:0]   ram_wdata_1,
  output logic [DATA_W-1:0]   ram_wdata_2,
  output logic                ram_rw_1,
  output logic                ram_rw_2,
  input  logic [DATA_W-1:0]   ram_rdata_1,
  input  logic [DATA_W-1:0]   ram_rdata_2
);

  typedef struct packed {
    src_t                src;
    logic [ADDR_W-1:0]   addr;
    logic                we;
    size_t               size;
    logic [2*DATA_W-1:0] wdata;
  } req_t;

  localparam req_t REQ_CLEAR = '{src: SRC_IF, addr: '0, we: 1'b0,
                                 size: SZ_BYTE, wdata: '0};

  state_t              state, state_nxt;
  req_t                req_q, req_nxt;
  logic                gnt_if, gnt_ls, accept;
  logic [2*DATA_W-1:0] rsp_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == ST_IDLE),
    .req_if (if_req_valid),
    .req_ls (ls_req_valid),
    .gnt_if (gnt_if),
    .gnt_ls (gnt_ls)
  );

  assign if_req_ready = gnt_if;
  assign ls_req_ready = gnt_ls;
  assign accept       = gnt_if | gnt_ls;

  always_comb begin
    req_nxt = REQ_CLEAR;
    if (gnt_ls) begin
      req_nxt.src   = SRC_LS;
      req_nxt.addr  = ls_addr;
      req_nxt.we    = ls_we;
      req_nxt.size  = size_t'(ls_size);
      req_nxt.wdata = ls_wdata;
    end else begin
      req_nxt.src   = SRC_IF;
      req_nxt.addr  = if_addr;
      req_nxt.size  = SZ_HALF;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      req_q <= REQ_CLEAR;
    end else begin
      state <= state_nxt;
      if (accept) req_q <= req_nxt;
    end
  end

  // Outputs decode straight from state so an asynchronous reset silences
  // the RAM and the response strobes in the same instant.
  always_comb begin
    ram_en       = 1'b0;
    ram_addr_1   = '0;
    ram_addr_2   = '0;
    ram_wdata_1  = '0;
    ram_wdata_2  = '0;
    ram_rw_1     = 1'b0;
    ram_rw_2     = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_valid = 1'b0;
    ls_rsp_data  = '0;
    rsp_data     = '0;
    case (state)
      ST_ACCESS: begin
        ram_en      = 1'b1;
        ram_addr_1  = req_q.addr;
        ram_addr_2  = req_q.addr + ADDR_W'(1);
        ram_rw_1    = req_q.we;
        ram_wdata_1 = req_q.wdata[DATA_W-1:0];
        // A byte store leaves port 2 reading; its data is never used.
        if (req_q.we && req_q.size == SZ_HALF) begin
          ram_rw_2    = 1'b1;
          ram_wdata_2 = req_q.wdata[2*DATA_W-1:DATA_W];
        end
      end
      ST_RESP: begin
        if (!req_q.we) begin
          rsp_data = (req_q.size == SZ_HALF) ? {ram_rdata_2, ram_rdata_1}
                                             : {{DATA_W{1'b0}}, ram_rdata_1};
        end
        if (req_q.src == SRC_LS) begin
          ls_rsp_valid = 1'b1;
          ls_rsp_data  = rsp_data;
        end else begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = rsp_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a behavioural RAM, a flat-array
// reference memory updated at each accepted request, and a scoreboard
// queue drained by a monitor that runs on every falling edge.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [7:0]  if_addr;
  logic [15:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_size, ls_rsp_valid;
  logic [7:0]  ls_addr;
  logic [15:0] ls_wdata, ls_rsp_data;
  logic        ram_en, ram_rw_1, ram_rw_2;
  logic [7:0]  ram_addr_1, ram_addr_2, ram_wdata_1, ram_wdata_2;
  logic [7:0]  ram_rdata_1, ram_rdata_2;

  mem_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_size(ls_size), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ram_en(ram_en), .ram_addr_1(ram_addr_1), .ram_addr_2(ram_addr_2),
    .ram_wdata_1(ram_wdata_1), .ram_wdata_2(ram_wdata_2),
    .ram_rw_1(ram_rw_1), .ram_rw_2(ram_rw_2),
    .ram_rdata_1(ram_rdata_1), .ram_rdata_2(ram_rdata_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] seed(input int i);
    return 8'((i * 29 + 7) ^ (i >> 3));
  endfunction

  // Behavioural dual-port RAM with registered, enable-held read data.
  logic [7:0] ram [256];
  bit         ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= seed(i);
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_rw_1) ram[ram_addr_1] <= ram_wdata_1; else ram_rdata_1 <= ram[ram_addr_1];
      if (ram_rw_2) ram[ram_addr_2] <= ram_wdata_2; else ram_rdata_2 <= ram[ram_addr_2];
    end
  end

  typedef struct {
    bit          src;   // 0 = fetch, 1 = load/store
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  bit   glog_src[$];
  int   glog_cyc[$];

  // Monitor / scoreboard / reference model.
  initial begin
    logic [7:0]  ref_mem [256];
    exp_t        e;
    logic [7:0]  a, a1, acc_a, acc_a1;
    logic [15:0] wd, d, acc_wd;
    bit          we, sz, hs_if, hs_ls, acc_valid, acc_we, acc_half;
    int          acc_cyc;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    acc_valid = 1'b0;
    acc_cyc   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        acc_valid = 1'b0;
      end else begin
        if (if_rsp_valid || ls_rsp_valid) begin
          check("rsp_exclusive", {63'd0, if_rsp_valid && ls_rsp_valid}, 64'd0);
          if (sb.size() == 0) begin
            check("rsp_unexpected", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_src", {63'd0, ls_rsp_valid}, {63'd0, e.src});
            check("rsp_cycle", cyc, e.due);
            check("rsp_data", ls_rsp_valid ? ls_rsp_data : if_rsp_data, e.data);
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check("rsp_missing", {62'd0, if_rsp_valid, ls_rsp_valid}, e.src ? 64'd1 : 64'd2);
        end
        if (!if_rsp_valid) check("if_rsp_idle", if_rsp_data, 64'd0);
        if (!ls_rsp_valid) check("ls_rsp_idle", ls_rsp_data, 64'd0);

        if (acc_valid && cyc == acc_cyc + 1) begin
          check("ram_en", ram_en, 1);
          check("ram_addr_1", ram_addr_1, acc_a);
          check("ram_addr_2", ram_addr_2, acc_a1);
          check("ram_rw_1", ram_rw_1, acc_we);
          check("ram_rw_2", ram_rw_2, acc_half);
          if (acc_we)   check("ram_wdata_1", ram_wdata_1, acc_wd[7:0]);
          if (acc_half) check("ram_wdata_2", ram_wdata_2, acc_wd[15:8]);
        end else begin
          check("ram_idle", {ram_en, ram_addr_1, ram_addr_2, ram_wdata_1,
                             ram_wdata_2, ram_rw_1, ram_rw_2}, 64'd0);
        end

        hs_if = if_req_valid && if_req_ready;
        hs_ls = ls_req_valid && ls_req_ready;
        check("single_grant", {63'd0, hs_if && hs_ls}, 64'd0);
        if (hs_if || hs_ls) begin
          if (hs_ls) begin
            a = ls_addr; we = ls_we; sz = ls_size; wd = ls_wdata;
          end else begin
            a = if_addr; we = 1'b0; sz = 1'b1; wd = 16'h0;
          end
          a1 = a + 8'd1;
          if (we) begin
            ref_mem[a] = wd[7:0];
            if (sz) ref_mem[a1] = wd[15:8];
            d = 16'h0;
          end else begin
            d = sz ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
          end
          sb.push_back('{src: hs_ls, data: d, due: cyc + 2});
          glog_src.push_back(hs_ls);
          glog_cyc.push_back(cyc);
          acc_valid = 1'b1; acc_cyc = cyc; acc_a = a; acc_a1 = a1;
          acc_we = we; acc_half = we && sz; acc_wd = wd;
        end
      end
    end
  end

  // Present one request and hold it until accepted; call at posedge+1.
  task automatic issue(input bit src, input logic [7:0] a, input bit we,
                       input bit sz, input logic [15:0] wd);
    bit done = 1'b0;
    if (!src) begin
      if_addr = a; if_req_valid = 1'b1;
    end else begin
      ls_addr = a; ls_we = we; ls_size = sz; ls_wdata = wd; ls_req_valid = 1'b1;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = src ? (ls_req_valid && ls_req_ready) : (if_req_valid && if_req_ready);
    end
    check("accept_timeout", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    if (!src) if_req_valid = 1'b0; else ls_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input int n);
    for (int i = 0; i < 40 && glog_src.size() < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_size = 1'b0; ls_wdata = '0;

    // Reset state: everything quiet, and fetch wins the first tie.
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp", {if_req_ready, ls_req_ready, if_rsp_valid, if_rsp_data,
                        ls_rsp_valid, ls_rsp_data}, 64'd0);
    check("reset_ram", {ram_en, ram_addr_1, ram_addr_2, ram_wdata_1,
                        ram_wdata_2, ram_rw_1, ram_rw_2}, 64'd0);
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    #1;
    check("reset_tie_grant", {if_req_ready, ls_req_ready}, 64'd2);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store then loads; upper store byte must not reach 0x11.
    issue(1, 8'h10, 1, 0, 16'h33A5);
    issue(1, 8'h10, 0, 0, 16'h0);
    check("byte_store_mem", ram[8'h10], 8'hA5);
    issue(1, 8'h10, 0, 1, 16'h0);
    drain();

    // Halfword store wrapping past 0xFF, then fetch across the wrap.
    issue(1, 8'hFF, 1, 1, 16'hBEEF);
    issue(0, 8'hFF, 0, 0, 16'h0);
    check("wrap_mem_ff", ram[8'hFF], 8'hEF);
    check("wrap_mem_00", ram[8'h00], 8'hBE);
    drain();

    // Latency: ls rises the cycle after a fetch is accepted.
    glog_src.delete(); glog_cyc.delete();
    issue(0, 8'h50, 0, 0, 16'h0);
    issue(1, 8'h51, 0, 0, 16'h0);
    check("latency_grants", glog_src.size(), 2);
    if (glog_src.size() == 2) check("latency_gap", glog_cyc[1] - glog_cyc[0], 3);
    drain();

    // Contention: both valid continuously from reset.
    rst_n = 1'b0;
    if_addr = 8'h20; if_req_valid = 1'b1;
    ls_addr = 8'h30; ls_we = 1'b0; ls_size = 1'b0; ls_req_valid = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    glog_src.delete(); glog_cyc.delete();
    wait_grants(4);
    ls_req_valid = 1'b0;
    wait_grants(5);
    if_req_valid = 1'b0;
    check("contention_grants", {63'd0, glog_src.size() >= 5}, 64'd1);
    if (glog_src.size() >= 5) begin
      for (int i = 0; i < 4; i++) begin
        check("contention_src", {63'd0, glog_src[i]}, i % 2);
        if (i > 0) check("contention_gap", glog_cyc[i] - glog_cyc[i-1], 3);
      end
    end
    drain();

    // Randomised traffic from both requesters.
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        issue(0, $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255)),
              0, 0, 16'h0);
      end
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        issue(1, $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      end
    join
    drain();

    // Reset during ACCESS aborts the load with no response.
    issue(1, 8'h40, 0, 1, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rsp", {if_rsp_valid, ls_rsp_valid, if_rsp_data, ls_rsp_data}, 64'd0);
    check("abort_ram", {ram_en, ram_addr_1, ram_addr_2, ram_wdata_1,
                        ram_wdata_2, ram_rw_1, ram_rw_2}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    if_addr = 8'h40; if_req_valid = 1'b1;
    #1;
    check("abort_idle_ready", if_req_ready, 1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    drain();
    issue(1, 8'h40, 0, 1, 16'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
